// File: rtl/noise_burst_ctrl.sv
// noise_burst_ctrl -- schedules on/off bursts for a bank of noise-generator lanes.
//
// A configuration (on/off lengths, burst count, lane count) is captured on a
// cfg_valid/cfg_ready handshake while idle. A start runs the schedule:
// ON for cfg_on cycles with the lane mask driven, OFF for cfg_off cycles with
// all lanes low, repeated cfg_bursts times (0 = until stop).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid / cfg_ready    configuration handshake (ready only in IDLE)
//   cfg_on, cfg_off          ON / OFF phase lengths in cycles (CNT_W)
//   cfg_bursts               burst count, 0 = run until stop
//   cfg_lanes                lanes per burst, clamped to NUM_LANES
//   start, stop              begin / abort a schedule
//   noise_en                 registered per-lane enables
//   busy                     high in ON or OFF
//   done, err                completion / rejected-start pulses
//   burst_cnt                bursts completed in the current schedule
//
// Optional build macro: NOISE_LANE_ROTATE_EN -- rotate the lane mask left by
// one lane at each ON entry after the first.
module noise_burst_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_W-1:0]     cfg_on,
  input  logic [CNT_W-1:0]     cfg_off,
  input  logic [7:0]           cfg_bursts,
  input  logic [4:0]           cfg_lanes,
  input  logic                 start,
  input  logic                 stop,
  output logic [NUM_LANES-1:0] noise_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           burst_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     on_q, on_d, off_q, off_d, cnt_q, cnt_d;
  logic [7:0]           bursts_q, bursts_d, burst_cnt_q, burst_cnt_d, bc_inc;
  logic [4:0]           lanes_q, lanes_d, lanes_clamped, eff_lanes;
  logic [CNT_W-1:0]     eff_on;
  logic [NUM_LANES-1:0] mask_q, mask_d, next_mask, therm;
  logic [NUM_LANES-1:0] noise_en_q, noise_en_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 cap;

  // A start coinciding with a capture uses the incoming configuration.
  always_comb begin
    lanes_clamped = (cfg_lanes > 5'(NUM_LANES)) ? 5'(NUM_LANES) : cfg_lanes;
    cap           = cfg_valid && (state_q == S_IDLE);
    eff_on        = cap ? cfg_on        : on_q;
    eff_lanes     = cap ? lanes_clamped : lanes_q;
    bc_inc        = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
  end

  // Thermometer mask: lanes 0..eff_lanes-1 set.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_therm
    assign therm[i] = (5'(i) < eff_lanes);
  end

  // Mask used on every ON entry after the first.
  always_comb begin
`ifdef NOISE_LANE_ROTATE_EN
    next_mask = (mask_q << 1) | (mask_q >> (NUM_LANES - 1));
`else
    next_mask = mask_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    on_d        = on_q;
    off_d       = off_q;
    bursts_d    = bursts_q;
    lanes_d     = lanes_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (cap) begin
      on_d     = cfg_on;
      off_d    = cfg_off;
      bursts_d = cfg_bursts;
      lanes_d  = lanes_clamped;
    end

    // cnt_q holds the cycles remaining in the current phase after this one.
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (eff_on == '0 || eff_lanes == 5'd0) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_ON;
            cnt_d       = eff_on - CNT_W'(1);
            mask_d      = therm;
            burst_cnt_d = 8'd0;
          end
        end
      end
      S_ON: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          burst_cnt_d = bc_inc;
          if (bursts_q != 8'd0 && bc_inc == bursts_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (off_q == '0) begin
            cnt_d  = on_q - CNT_W'(1);
            mask_d = next_mask;
          end else begin
            state_d = S_OFF;
            cnt_d   = off_q - CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_OFF: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ON;
          cnt_d   = on_q - CNT_W'(1);
          mask_d  = next_mask;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    noise_en_d = (state_d == S_ON) ? mask_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      on_q        <= CNT_W'(1);
      off_q       <= '0;
      bursts_q    <= 8'd1;
      lanes_q     <= 5'd1;
      cnt_q       <= '0;
      mask_q      <= '0;
      burst_cnt_q <= 8'd0;
      noise_en_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_q        <= on_d;
      off_q       <= off_d;
      bursts_q    <= bursts_d;
      lanes_q     <= lanes_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      burst_cnt_q <= burst_cnt_d;
      noise_en_q  <= noise_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign noise_en  = noise_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_noise_burst_ctrl.sv
// Bench for noise_burst_ctrl: table of schedules expanded into per-cycle
// expected outputs on a queue, popped and compared at each falling edge.
module tb_noise_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, start, stop;
  logic [15:0] cfg_on, cfg_off;
  logic [7:0]  cfg_bursts, burst_cnt;
  logic [4:0]  cfg_lanes;
  logic [3:0]  noise_en;
  logic        busy, done, err;

  always #5 clk = ~clk;

  noise_burst_ctrl #(.NUM_LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_bursts(cfg_bursts),
    .cfg_lanes(cfg_lanes), .start(start), .stop(stop), .noise_en(noise_en),
    .busy(busy), .done(done), .err(err), .burst_cnt(burst_cnt)
  );

  typedef struct packed {
    logic [3:0] ne;
    logic       busy, done, err, rdy;
    logic [7:0] bc;
  } exp_t;

  // mode: 0 = cfg one cycle before start, 1 = cfg with start, 2 = no cfg
  typedef struct {
    string      name;
    int         mode, on, off, bursts, lanes, stop_at;
    bit         poke;      // start + junk cfg while busy at cycle 2
    logic [3:0] exp_mask;
    bit         exp_err;
  } vec_t;

  exp_t       sbq[$];
  int         errors = 0, checks = 0;
  logic [7:0] cur_bc = 8'd0;

  task automatic push(input logic [3:0] ne, input logic b, d, e,
                      input logic [7:0] bc);
    exp_t x;
    x.ne = ne; x.busy = b; x.done = d; x.err = e; x.rdy = !b; x.bc = bc;
    sbq.push_back(x);
  endtask

  task automatic check_pop(input string name, input int k);
    exp_t x, a;
    x = sbq.pop_front();
    a.ne = noise_en; a.busy = busy; a.done = done; a.err = err;
    a.rdy = cfg_ready; a.bc = burst_cnt;
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s cyc%0d: got ne=%b busy=%b done=%b err=%b rdy=%b bc=%0d want ne=%b busy=%b done=%b err=%b rdy=%b bc=%0d",
               name, k, a.ne, a.busy, a.done, a.err, a.rdy, a.bc,
               x.ne, x.busy, x.done, x.err, x.rdy, x.bc);
    end
  endtask

  // Expand a schedule into the expected output of every cycle after start.
  task automatic push_sched(input int on, off, bursts, input logic [3:0] mask,
                            input int stop_at);
    int         k = 0;
    logic [7:0] bc = 8'd0;
    logic [3:0] m = mask;
    bit         fin = 0, first = 1;
    while (!fin) begin
`ifdef NOISE_LANE_ROTATE_EN
      if (!first) m = {m[2:0], m[3]};
`endif
      first = 0;
      for (int i = 0; i < on && !fin; i++) begin
        k++;
        if (stop_at != 0 && k > stop_at) fin = 1;
        else push(m, 1'b1, 1'b0, 1'b0, bc);
      end
      if (fin) break;
      if (bc != 8'hFF) bc++;
      if (bursts != 0 && int'(bc) == bursts) begin
        push(4'b0, 1'b0, 1'b1, 1'b0, bc);
        push(4'b0, 1'b0, 1'b0, 1'b0, bc);
        cur_bc = bc;
        return;
      end
      for (int i = 0; i < off && !fin; i++) begin
        k++;
        if (stop_at != 0 && k > stop_at) fin = 1;
        else push(4'b0, 1'b1, 1'b0, 1'b0, bc);
      end
    end
    push(4'b0, 1'b0, 1'b0, 1'b0, bc);
    push(4'b0, 1'b0, 1'b0, 1'b0, bc);
    cur_bc = bc;
  endtask

  task automatic set_cfg(input int on, off, bursts, lanes);
    cfg_on = 16'(on); cfg_off = 16'(off);
    cfg_bursts = 8'(bursts); cfg_lanes = 5'(lanes);
  endtask

  task automatic run(input vec_t v);
    int k = 1;
    if (v.mode == 0) begin
      set_cfg(v.on, v.off, v.bursts, v.lanes);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      set_cfg(9, 9, 9, 9);
    end else if (v.mode == 1) begin
      set_cfg(v.on, v.off, v.bursts, v.lanes);
      cfg_valid = 1'b1;
    end
    if (v.exp_err) begin
      push(4'b0, 1'b0, 1'b0, 1'b1, cur_bc);
      push(4'b0, 1'b0, 1'b0, 1'b0, cur_bc);
    end else begin
      push_sched(v.on, v.off, v.bursts, v.exp_mask, v.stop_at);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_valid = 1'b0;
    while (sbq.size() > 0) begin
      check_pop(v.name, k);
      stop = (k == v.stop_at);
      if (v.poke && k == 2) begin
        start = 1'b1; cfg_valid = 1'b1; set_cfg(0, 7, 1, 0);
      end else begin
        start = 1'b0; cfg_valid = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
  endtask

  vec_t vt[8];
  vec_t dflt;

  initial begin
    vt[0] = '{"basic",     0, 3, 2, 2, 2, 0,  1, 4'b0011, 0};
    vt[1] = '{"on0_err",   1, 0, 1, 1, 1, 0,  0, 4'b0000, 1};
    vt[2] = '{"clamp_stop",1, 4, 0, 0, 7, 10, 0, 4'b1111, 0};
    vt[3] = '{"rotate",    0, 1, 1, 4, 1, 0,  0, 4'b0001, 0};
    vt[4] = '{"b2b",       1, 2, 0, 2, 3, 0,  0, 4'b0111, 0};
    vt[5] = '{"one_cycle", 0, 1, 0, 1, 4, 0,  0, 4'b1111, 0};
    vt[6] = '{"lanes0_err",0, 5, 3, 1, 0, 0,  0, 4'b0000, 1};
    vt[7] = '{"long_off",  1, 2, 5, 3, 1, 0,  0, 4'b0001, 0};
    dflt  = '{"dflt_cfg",  2, 1, 0, 1, 1, 0,  0, 4'b0001, 0};

    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(4'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check_pop("reset", 0);

    // Stored configuration after reset: on=1 off=0 bursts=1 lanes=1.
    run(dflt);

    for (int i = 0; i < 8; i++) run(vt[i]);

    // start and stop together: stays idle
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    push(4'b0, 1'b0, 1'b0, 1'b0, cur_bc);
    check_pop("start_stop", 1);

    // stop alone in idle: no effect
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    push(4'b0, 1'b0, 1'b0, 1'b0, cur_bc);
    check_pop("stop_idle", 1);

    // reset mid-ON
    set_cfg(100, 0, 1, 3); cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      push(4'b0111, 1'b1, 1'b0, 1'b0, 8'd0);
      check_pop("pre_rst", k);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    push(4'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check_pop("mid_rst", 1);
    rst = 1'b0;
    @(negedge clk);
    push(4'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check_pop("post_rst", 1);
    cur_bc = 8'd0;
    run(dflt);
    run(vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
